// File: rtl/muldiv_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_pkg : funct3 codes, FSM state encoding and operand signedness helpers
// Rev 1.0
// ----------------------------------------------------------------------------
package muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  function automatic logic a_is_signed(input logic [2:0] f);
    return (f == MD_MUL) || (f == MD_MULH) || (f == MD_MULHSU) ||
           (f == MD_DIV) || (f == MD_REM);
  endfunction

  function automatic logic b_is_signed(input logic [2:0] f);
    return (f == MD_MUL) || (f == MD_MULH) || (f == MD_DIV) || (f == MD_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_sign.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_sign : sign analysis and conditional two's-complement negation
// Rev 1.0
// ----------------------------------------------------------------------------
module muldiv_sign
  import muldiv_pkg::*;
#(
  parameter int WA        = 32,
  parameter int WB        = 32,
  parameter bit OUT_STAGE = 1'b0
) (
  input  logic [2:0]    op,
  input  logic          a_msb,
  input  logic          b_msb,
  input  logic [WA-1:0] a,
  input  logic [WB-1:0] b,
  output logic [WA-1:0] a_o,
  output logic [WB-1:0] b_o
);

  logic sa;
  logic sb;
  logic neg_a;
  logic neg_b;

  // Input stage: magnitudes of both operands. Output stage: a is the product or
  // quotient (negative iff signs differ), b is the remainder (sign of dividend).
  always_comb begin
    sa    = a_is_signed(op) & a_msb;
    sb    = b_is_signed(op) & b_msb;
    neg_a = OUT_STAGE ? (sa ^ sb) : sa;
    neg_b = OUT_STAGE ? sa : sb;
    a_o   = neg_a ? (~a + WA'(1)) : a;
    b_o   = neg_b ? (~b + WB'(1)) : b;
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_unit : iterative RV32M multiply/divide, one bit per cycle, valid/ready
// Rev 1.0
// ----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int              CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] SMIN  = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   rs1_q, rs1_d;
  logic [XLEN-1:0]   rs2_q, rs2_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              out_valid_q, out_valid_d;

  logic              idle;
  logic [2:0]        src_op;
  logic [XLEN-1:0]   src_a;
  logic [XLEN-1:0]   src_b;
  logic              div_zero;
  logic              special;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     rem_sh;
  logic              q_bit;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] fix_in;
  logic [2*XLEN-1:0] fix_prod;
  logic [XLEN-1:0]   fix_rem;
  logic [XLEN-1:0]   norm_res;

  // Live inputs while idle so the accumulator is seeded at accept; latched copies after.
  always_comb begin
    idle     = (state_q == ST_IDLE);
    src_op   = idle ? op  : op_q;
    src_a    = idle ? rs1 : rs1_q;
    src_b    = idle ? rs2 : rs2_q;
    div_zero = src_op[2] && (src_b == '0);
    special  = div_zero ||
               (src_op[2] && !src_op[0] && (src_a == SMIN) && (src_b == '1));
  end

  muldiv_sign #(
    .WA        (XLEN),
    .WB        (XLEN),
    .OUT_STAGE (1'b0)
  ) u_sign_in (
    .op    (src_op),
    .a_msb (src_a[XLEN-1]),
    .b_msb (src_b[XLEN-1]),
    .a     (src_a),
    .b     (src_b),
    .a_o   (mag_a),
    .b_o   (mag_b)
  );

  // Shift-add keeps the multiplier in the low half; restoring divide keeps remainder:quotient.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_a} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    q_bit    = (rem_sh >= {1'b0, mag_b});
    div_next = {(q_bit ? (rem_sh[XLEN-1:0] - mag_b) : rem_sh[XLEN-1:0]),
                acc_q[XLEN-2:0], q_bit};
    fix_in   = op_q[2] ? {{XLEN{1'b0}}, acc_q[XLEN-1:0]} : acc_q;
  end

  muldiv_sign #(
    .WA        (2*XLEN),
    .WB        (XLEN),
    .OUT_STAGE (1'b1)
  ) u_sign_out (
    .op    (op_q),
    .a_msb (rs1_q[XLEN-1]),
    .b_msb (rs2_q[XLEN-1]),
    .a     (fix_in),
    .b     (acc_q[2*XLEN-1:XLEN]),
    .a_o   (fix_prod),
    .b_o   (fix_rem)
  );

  always_comb begin
    if (op_q[2])
      norm_res = op_q[1] ? fix_rem : fix_prod[XLEN-1:0];
    else
      norm_res = (op_q[1:0] == 2'b00) ? fix_prod[XLEN-1:0] : fix_prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_d    = op;
            rs1_d   = rs1;
            rs2_d   = rs2;
            cnt_d   = CNT_W'(XLEN);
            acc_d   = {{XLEN{1'b0}}, (op[2] ? mag_a : mag_b)};
            // Divide-by-zero and signed overflow skip the iteration entirely.
            state_d = special ? ST_FIX : ST_CALC;
          end
        end
        ST_CALC: begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1))
            state_d = ST_FIX;
        end
        ST_FIX: begin
          if (div_zero)
            result_d = op_q[1] ? rs1_q : '1;
          else if (special)
            result_d = op_q[1] ? '0 : rs1_q;
          else
            result_d = norm_res;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = idle;
  assign busy      = !idle;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_muldiv_unit : randomized and directed bench with a behavioural RV32M model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam logic [31:0] SMIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic        m_busy = 1'b0;
  logic [31:0] m_result = 32'd0;
  int          m_ready_cyc = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RV32M semantics computed directly with 64-bit arithmetic.
  function automatic logic [31:0] ref_fn(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb, ub_s, ps;
    logic [63:0]        ua, ub, pu;
    logic               ovf;
    sa   = {{32{a[31]}}, a};
    sb   = {{32{b[31]}}, b};
    ua   = {32'd0, a};
    ub   = {32'd0, b};
    ub_s = ub;
    ovf  = (a == SMIN) && (b == 32'hFFFF_FFFF);
    ps   = '0;
    pu   = '0;
    case (f)
      3'd0: begin ps = sa * sb;   return ps[31:0];  end
      3'd1: begin ps = sa * sb;   return ps[63:32]; end
      3'd2: begin ps = sa * ub_s; return ps[63:32]; end
      3'd3: begin pu = ua * ub;   return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        ps = sa / sb; return ps[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        pu = ua / ub; return pu[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        ps = sa % sb; return ps[31:0];
      end
      default: begin
        if (b == 0) return a;
        pu = ua % ub; return pu[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0)) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == SMIN && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return SMIN;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Cycle-level compare process against the transaction-level model.
  always @(negedge clk) begin
    logic exp_v;
    if (!rst_n) begin
      m_busy = 1'b0;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
    end else begin
      exp_v = m_busy && (cyc >= m_ready_cyc);
      chk("mon_in_ready", 32'(in_ready), 32'(!m_busy));
      chk("mon_busy", 32'(busy), 32'(m_busy));
      chk("mon_out_valid", 32'(out_valid), 32'(exp_v));
      if (exp_v) chk("mon_result", result, m_result);
      if (flush) begin
        m_busy = 1'b0;
      end else if (!m_busy && in_valid) begin
        m_busy      = 1'b1;
        m_result    = ref_fn(op, rs1, rs2);
        m_ready_cyc = cyc + 1 + ref_lat(op, rs1, rs2);
      end else if (exp_v && out_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    in_valid = 1'b1; op = f; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op  = 3'($urandom_range(0, 7));
    rs1 = $urandom;
    rs2 = $urandom;
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] lit, input int lat,
                        input int hold);
    int n;
    chk({name, "_model"}, ref_fn(f, a, b), lit);
    start_op(f, a, b);
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    chk({name, "_latency"}, 32'(n), 32'(lat));
    chk({name, "_result"}, result, lit);
    repeat (hold) begin
      @(posedge clk); #1;
      chk({name, "_hold_result"}, result, lit);
      chk({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "_release"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_result", result, 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mul_neg",   3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
    run_op("mulh_min",  3'd1, SMIN,          SMIN,          32'h4000_0000, 33, 0);
    run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
    run_op("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0);
    run_op("div_m7_2",  3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 0);
    run_op("rem_m7_2",  3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 0);
    run_op("divu_100",  3'd5, 32'd100,       32'd7,         32'd14,        33, 0);
    run_op("remu_100",  3'd7, 32'd100,       32'd7,         32'd2,         33, 0);
    run_op("div_by0",   3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  0);
    run_op("rem_by0",   3'd6, 32'd5,         32'd0,         32'd5,         1,  0);
    run_op("divu_by0",  3'd5, 32'h1234,      32'd0,         32'hFFFF_FFFF, 1,  0);
    run_op("remu_by0",  3'd7, 32'h1234,      32'd0,         32'h1234,      1,  0);
    run_op("div_ovf",   3'd4, SMIN,          32'hFFFF_FFFF, SMIN,          1,  0);
    run_op("rem_ovf",   3'd6, SMIN,          32'hFFFF_FFFF, 32'd0,         1,  0);
    run_op("mul_hold",  3'd0, 32'd3,         32'd5,         32'd15,        33, 10);

    // Flush mid-iteration discards the operation.
    start_op(3'd0, 32'h1234, 32'h5678);
    repeat (11) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    run_op("mul_after_flush", 3'd0, 32'd3, 32'd4, 32'd12, 33, 0);

    // Request coincident with flush is dropped.
    in_valid = 1'b1; flush = 1'b1; op = 3'd0; rs1 = 32'd9; rs2 = 32'd9;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_drop_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-iteration.
    start_op(3'd5, 32'hFFFF_FFFF, 32'd3);
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    chk("async_rst_result", result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("divu_after_rst", 3'd5, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 33, 0);

    // Randomized traffic with backpressure and occasional flushes.
    for (int i = 0; i < 4000; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      op        = 3'($urandom_range(0, 7));
      rs1       = rnd_opnd();
      rs2       = rnd_opnd();
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 99) == 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (40) begin @(posedge clk); #1; end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
